// File: rtl/tx_frame_arbiter.sv
// Round-robin whole-frame arbiter in front of the RGMII TX MAC, with a minimum
// inter-frame gap, a per-grant watchdog and a hard block while the TX link is down or changing.
module tx_frame_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int IFG_CYCLES       = 12,
  parameter int MAX_FRAME_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       link_up,
  input  logic                       changing,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         frame_done,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       aborted,
  output logic                       blocked
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_FRAME_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_IFG  = CNT_W'(IFG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    S_BLOCKED,
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [ID_W-1:0]    active_id_d;
  logic               aborted_d;
  logic               blocked_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]   counter, counter_d;

  logic               halt;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    next_ptr;
  logic               owner_end;

  assign halt      = !link_up || changing;
  assign owner_end = frame_done[active_id] || !req[active_id];
  assign next_ptr  = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;

  // Scan from rr_ptr upward with wrap; iterating k downward lets the nearest hit win.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (rr_ptr == ID_W'(j) && req[(j + k) % NUM_REQ]) begin
          pick_valid = 1'b1;
          pick_id    = ID_W'((j + k) % NUM_REQ);
        end
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    active_id_d = active_id;
    aborted_d   = 1'b0;
    rr_ptr_d    = rr_ptr;
    counter_d   = counter;

    unique case (state)
      S_BLOCKED: begin
        grant_d = '0;
        if (!halt) begin
          state_d   = S_GAP;
          counter_d = CNT_IFG;
        end
      end

      S_IDLE: begin
        if (halt) begin
          state_d   = S_BLOCKED;
          counter_d = '0;
        end else if (pick_valid) begin
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          active_id_d      = pick_id;
          counter_d        = '0;
          state_d          = S_GRANT;
        end
      end

      S_GRANT: begin
        if (halt) begin
          // Forced revoke: rr_ptr is left alone so the same source is served first.
          grant_d   = '0;
          aborted_d = 1'b1;
          counter_d = '0;
          state_d   = S_BLOCKED;
        end else if (owner_end || counter == CNT_LAST) begin
          grant_d   = '0;
          aborted_d = !owner_end;
          rr_ptr_d  = next_ptr;
          counter_d = CNT_IFG;
          state_d   = S_GAP;
        end else if (counter != CNT_SAT) begin
          counter_d = counter + 1'b1;
        end
      end

      S_GAP: begin
        grant_d = '0;
        if (halt) begin
          state_d   = S_BLOCKED;
          counter_d = '0;
        end else begin
          if (counter != '0) counter_d = counter - 1'b1;
          if (counter <= CNT_W'(1)) state_d = S_IDLE;
        end
      end
    endcase

    blocked_d = (state_d == S_BLOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_BLOCKED;
      grant     <= '0;
      active_id <= '0;
      aborted   <= 1'b0;
      blocked   <= 1'b1;
      rr_ptr    <= '0;
      counter   <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      active_id <= active_id_d;
      aborted   <= aborted_d;
      blocked   <= blocked_d;
      rr_ptr    <= rr_ptr_d;
      counter   <= counter_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: directed vector table, a watchdog
// sequence, and randomized traffic compared against a behavioural model.
module tb_tx_frame_arbiter;

  localparam int N    = 2;
  localparam int IFG  = 12;
  localparam int MAXF = 4096;

  logic         clk = 1'b0;
  logic         reset;
  logic         link_up;
  logic         changing;
  logic [N-1:0] req;
  logic [N-1:0] frame_done;
  logic [N-1:0] grant;
  logic         active_id;
  logic         aborted;
  logic         blocked;

  tx_frame_arbiter #(
    .NUM_REQ          (N),
    .IFG_CYCLES       (IFG),
    .MAX_FRAME_CYCLES (MAXF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .link_up    (link_up),
    .changing   (changing),
    .req        (req),
    .frame_done (frame_done),
    .grant      (grant),
    .active_id  (active_id),
    .aborted    (aborted),
    .blocked    (blocked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: owner (-1 = none), remaining gap, grant age, halted flag.
  int m_owner  = -1;
  int m_gap    = 0;
  int m_age    = 0;
  int m_ptr    = 0;
  int m_last   = 0;
  bit m_halted = 1'b1;
  bit m_abort  = 1'b0;

  task automatic model_step(input logic rst, input logic lk, input logic ch,
                            input logic [N-1:0] rq, input logic [N-1:0] fd);
    bit halt;
    bit done;
    halt    = !lk || ch;
    m_abort = 1'b0;
    if (rst) begin
      m_owner = -1; m_halted = 1'b1; m_gap = 0; m_ptr = 0; m_last = 0;
    end else if (m_halted) begin
      if (!halt) begin
        m_halted = 1'b0;
        m_gap    = IFG;
      end
    end else if (m_owner >= 0) begin
      done = fd[m_owner] || !rq[m_owner];
      if (halt) begin
        m_owner = -1; m_abort = 1'b1; m_halted = 1'b1;
      end else if (done || m_age == MAXF - 1) begin
        m_abort = !done;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = IFG;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      if (halt) begin
        m_halted = 1'b1; m_gap = 0;
      end else begin
        m_gap--;
      end
    end else if (halt) begin
      m_halted = 1'b1;
    end else if (rq != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_last = m_owner;
      m_age  = 0;
    end
  endtask

  task automatic tick();
    model_step(reset, link_up, changing, req, frame_done);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int           n;
    logic         rst, link, chg;
    logic [N-1:0] rq, fd;
    logic [N-1:0] g;
    logic         ab, bl, id;
  } vec_t;

  function automatic vec_t mk(int n, logic rst, logic link, logic chg, logic [N-1:0] rq,
                              logic [N-1:0] fd, logic [N-1:0] g, logic ab, logic bl, logic id);
    vec_t v;
    v.n = n; v.rst = rst; v.link = link; v.chg = chg; v.rq = rq; v.fd = fd;
    v.g = g; v.ab = ab; v.bl = bl; v.id = id;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    bit             ok;
    int             waited;
    logic [N-1:0]   eg;

    reset = 1'b1; link_up = 1'b0; changing = 1'b0; req = '0; frame_done = '0;

    //               n  rst lk ch  req    fd     grant  ab bl id
    vecs.push_back(mk(2,  1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
    vecs.push_back(mk(1,  0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(11, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b00, 2'b01, 0, 0, 0));
    vecs.push_back(mk(49, 0, 1, 0, 2'b11, 2'b00, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(11, 0, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b00, 2'b10, 0, 0, 1));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b01, 2'b10, 0, 0, 1));
    vecs.push_back(mk(9,  0, 1, 0, 2'b11, 2'b00, 2'b10, 0, 0, 1));
    vecs.push_back(mk(1,  0, 1, 1, 2'b11, 2'b10, 2'b00, 1, 1, 1));
    vecs.push_back(mk(1,  0, 1, 1, 2'b11, 2'b00, 2'b00, 0, 1, 1));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 1));
    vecs.push_back(mk(12, 0, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 1));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b00, 2'b10, 0, 0, 1));
    vecs.push_back(mk(1,  0, 0, 0, 2'b11, 2'b10, 2'b00, 1, 1, 1));
    vecs.push_back(mk(1,  0, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, 1));
    vecs.push_back(mk(13, 0, 1, 0, 2'b11, 2'b00, 2'b10, 0, 0, 1));
    vecs.push_back(mk(1,  1, 1, 0, 2'b11, 2'b00, 2'b00, 0, 1, 0));
    vecs.push_back(mk(1,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst; link_up = vecs[i].link; changing = vecs[i].chg;
      req = vecs[i].rq; frame_done = vecs[i].fd;
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d grant", i),     grant,     vecs[i].g);
      check($sformatf("vec%0d aborted", i),   aborted,   vecs[i].ab);
      check($sformatf("vec%0d blocked", i),   blocked,   vecs[i].bl);
      check($sformatf("vec%0d active_id", i), active_id, vecs[i].id);
    end

    // Watchdog: owner 0 never finishes while req[1] toggles.
    reset = 1'b1; link_up = 1'b0; changing = 1'b0; req = '0; frame_done = '0;
    repeat (2) tick();
    reset = 1'b0; link_up = 1'b1; req = 2'b01;
    repeat (14) tick();
    check("wd first grant", grant, 2'b01);
    ok = 1'b1;
    for (int i = 1; i < MAXF; i++) begin
      req = {i[0], 1'b1};
      tick();
      if (grant !== 2'b01 || aborted !== 1'b0) ok = 1'b0;
    end
    check("wd hold", ok, 1'b1);
    req = 2'b11;
    tick();
    check("wd aborted", aborted, 1'b1);
    check("wd grant drop", grant, 2'b00);
    check("wd not blocked", blocked, 1'b0);
    tick();
    check("wd aborted pulse", aborted, 1'b0);
    waited = 1;
    while (grant === 2'b00 && waited < 30) begin
      tick();
      waited++;
    end
    check("wd gap length", waited, 13);
    check("wd next owner", grant, 2'b10);

    // Randomized traffic against the model.
    reset = 1'b1; link_up = 1'b1; changing = 1'b0; req = '0; frame_done = '0;
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      link_up  = ($urandom_range(0, 63) != 0);
      changing = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      frame_done = '0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 19) == 0) frame_done[b] = 1'b1;
      tick();
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check("rnd grant",     grant,           eg);
      check("rnd aborted",   aborted,         m_abort);
      check("rnd blocked",   blocked,         m_halted);
      check("rnd active_id", active_id,       m_last[0]);
      check("rnd onehot",    $onehot0(grant), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
